fifo_write_arbiter: RTL and testbench
=====================================

// Module: fifo_write_arbiter
// PURPOSE
//  Round-robin arbiter that shares the write port of one async_fifo among NUM_REQ
//  requesters in the write-clock domain.
//  Grants one requester at a time for a bounded burst of at most MAX_BURST beats.
//  Drives the FIFO's write_en/data_in and stalls on the FIFO full flag.
//  Sits between write-side producers and async_fifo (write_en, data_in, full).
// PARAMETERS
//  DATA_LEN   32  width of each data word (matches async_fifo DATA_LEN)
//  NUM_REQ    4   number of requesters, >=2
//  MAX_BURST  8   max beats per grant before forced re-arbitration, >=1
// PORTS
//  wclk          in   1                  write-domain clock, all logic on posedge
//  rst_n         in   1                  asynchronous active-low reset
//  arb_en_i      in   1                  1 = new grants allowed; 0 = finish current burst, then hold
//  req_valid_i   in   NUM_REQ            per-requester data valid
//  req_data_i    in   NUM_REQ*DATA_LEN   requester i data in bits [i*DATA_LEN +: DATA_LEN]
//  req_ready_o   out  NUM_REQ            per-requester accept; beat moves when valid&ready
//  wfull_i       in   1                  async_fifo full flag
//  write_en_o    out  1                  to async_fifo write_en
//  wdata_o       out  DATA_LEN           to async_fifo data_in
//  grant_o       out  NUM_REQ            registered one-hot grant, 0 when idle
//  busy_o        out  1                  1 while in BURST state
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE, grant_o=0, beat_cnt=0, busy_o=0.
//   - last pointer = NUM_REQ-1, so requester 0 wins first.
//   - Hence req_ready_o=0, write_en_o=0, wdata_o=0.
//  FSM IDLE:
//   - If arb_en_i && |req_valid_i: pick the first valid index searching last+1, last+2, ...
//     (mod NUM_REQ). Register it one-hot in grant_o, clear beat_cnt, go to BURST.
//   - Otherwise stay in IDLE.
//  FSM BURST (granted index g):
//   - req_ready_o[g] = !wfull_i (combinational); all other ready bits are 0.
//   - Beat = req_valid_i[g] & req_ready_o[g].
//   - write_en_o = beat (combinational, zero latency).
//   - wdata_o = req_data_i[g]; wdata_o = 0 when no grant.
//   - On a beat: beat_cnt++.
//   - Release when (beat && beat_cnt==MAX_BURST-1) OR req_valid_i[g]==0.
//   - On release: last=g, grant_o=0, state=IDLE. One idle bubble cycle between grants.
//   - wfull_i=1: ready low, no write, beat_cnt held, grant held. Full never causes release.
//   - Valid low takes priority, even while full: release on that same edge.
//   - arb_en_i is ignored in BURST; it only gates new grants from IDLE.
//  Widths:
//   - beat_cnt is $clog2(MAX_BURST+1) bits and never exceeds MAX_BURST-1.
//   - Pointer wraps NUM_REQ-1 -> 0.
//  Guarantees:
//   - Never more than one ready bit high.
//   - write_en_o never 1 while wfull_i=1 (no FIFO overflow).
//   - Requesters see ready only in the granted cycle.
//  Reset mid-burst:
//   - Everything clears immediately; a partial beat is not written.
//   - After release, arbitration restarts at requester 0.
// TESTING
//  1. Reset with all req_valid_i=1 -> grant_o=0, write_en_o=0, all ready 0 while rst_n=0;
//     grant_o=4'b0001 one cycle after release.
//  2. Only req1 valid, data 0xA0,0xA1,0xA2, then drops -> grant_o=4'b0010 next cycle;
//     3 consecutive write_en_o pulses with those words; back to IDLE, grant_o=0 on drop.
//  3. All four valid continuously, MAX_BURST=8 -> grants 0,1,2,3,0 each exactly
//     8 write_en_o pulses, 1 idle cycle between, data from the granted source only.
//  4. wfull_i=1 for 5 cycles after beat 3 of req2 -> ready/write_en_o low for those 5 cycles;
//     beat_cnt held; beats 4..8 resume; exactly 8 words total.
//  5. arb_en_i=0 mid-burst of req0 -> burst completes 8 beats; no new grant while low;
//     req1 granted 1 cycle after arb_en_i=1.
//  6. rst_n pulsed low at beat 5 of req3 -> outputs 0 immediately; after release
//     req0 granted first; no stray write_en_o.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one async_fifo write port among NUM_REQ producers, bursts of at most MAX_BURST beats.
// Grant registered one cycle after request; beats pass combinationally; wfull_i stalls a burst but never releases it.
module fifo_write_arbiter #(
   parameter int DATA_LEN  = 32,
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 8
) (
   input  logic                        wclk,
   input  logic                        rst_n,
   input  logic                        arb_en_i,
   input  logic [NUM_REQ-1:0]          req_valid_i,
   input  logic [NUM_REQ*DATA_LEN-1:0] req_data_i,
   output logic [NUM_REQ-1:0]          req_ready_o,
   input  logic                        wfull_i,
   output logic                        write_en_o,
   output logic [DATA_LEN-1:0]         wdata_o,
   output logic [NUM_REQ-1:0]          grant_o,
   output logic                        busy_o
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   localparam logic [0:0]       IDLE     = 1'b0;
   localparam logic [0:0]       BURST    = 1'b1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   logic [0:0]          state;
   logic [IDX_W-1:0]    gidx;
   logic [IDX_W-1:0]    last_ptr;
   logic [IDX_W-1:0]    pick;
   logic [IDX_W-1:0]    cand;
   logic                found;
   logic [CNT_W-1:0]    beat_cnt;
   logic                g_valid;
   logic [DATA_LEN-1:0] g_data;
   logic                beat;
   logic                rel;

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] p);
      return (p == LAST_IDX) ? '0 : p + 1'b1;
   endfunction

   // First valid requester after the last one served, wrapping around.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      cand  = last_ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = wrap_inc(cand);
         if (!found && req_valid_i[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      g_valid = 1'b0;
      g_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_o[i]) begin
            g_valid = req_valid_i[i];
            g_data  = req_data_i[i*DATA_LEN +: DATA_LEN];
         end
      end
   end

   assign busy_o      = (state == BURST);
   assign req_ready_o = (busy_o && !wfull_i) ? grant_o : '0;
   assign beat        = busy_o && g_valid && !wfull_i;
   assign write_en_o  = beat;
   assign wdata_o     = g_data;
   // A dropped valid ends the burst even while the FIFO is full.
   assign rel         = busy_o && (!g_valid || (beat && (beat_cnt == CNT_LAST)));

   always_ff @(posedge wclk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         grant_o  <= '0;
         gidx     <= '0;
         last_ptr <= LAST_IDX;
         beat_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_en_i && found) begin
                  state    <= BURST;
                  gidx     <= pick;
                  grant_o  <= NUM_REQ'(1) << pick;
                  beat_cnt <= '0;
               end
            end
            BURST: begin
               if (rel) begin
                  state    <= IDLE;
                  last_ptr <= gidx;
                  grant_o  <= '0;
                  beat_cnt <= '0;
               end else if (beat) begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: fixed vector table, directed corner sequences, randomized run against a reference model.
`timescale 1ns/1ps
module tb_fifo_write_arbiter;
   localparam int DW = 32;
   localparam int NR = 4;
   localparam int MB = 8;

   logic              wclk = 1'b0;
   logic              rst_n;
   logic              arb_en_i;
   logic [NR-1:0]     req_valid_i;
   logic [NR*DW-1:0]  req_data_i;
   logic [NR-1:0]     req_ready_o;
   logic              wfull_i;
   logic              write_en_o;
   logic [DW-1:0]     wdata_o;
   logic [NR-1:0]     grant_o;
   logic              busy_o;

   always #5 wclk = ~wclk;

   fifo_write_arbiter #(.DATA_LEN(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
      .wclk(wclk), .rst_n(rst_n), .arb_en_i(arb_en_i), .req_valid_i(req_valid_i),
      .req_data_i(req_data_i), .req_ready_o(req_ready_o), .wfull_i(wfull_i),
      .write_en_o(write_en_o), .wdata_o(wdata_o), .grant_o(grant_o), .busy_o(busy_o)
   );

   int n_chk = 0;
   int n_err = 0;

   // Reference: granted requester (-1 = none), last served, beats completed.
   int m_g, m_last, m_beats;

   typedef struct {
      logic          en;
      logic          full;
      logic [NR-1:0] valid;
      logic [DW-1:0] d;
      logic [NR-1:0] e_grant;
      logic [NR-1:0] e_ready;
      logic          e_we;
      logic [DW-1:0] e_wdata;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_g = -1;
      m_last = NR - 1;
      m_beats = 0;
   endtask

   task automatic model_check();
      logic [NR-1:0] eg, er;
      logic          ew;
      logic [DW-1:0] ed;
      eg = '0; er = '0; ew = 1'b0; ed = '0;
      if (m_g >= 0) begin
         eg[m_g] = 1'b1;
         if (!wfull_i) er[m_g] = 1'b1;
         ew = req_valid_i[m_g] && !wfull_i;
         ed = req_data_i[m_g*DW +: DW];
      end
      chk("model grant", grant_o, eg);
      chk("model ready", req_ready_o, er);
      chk("model write_en", write_en_o, ew);
      chk("model wdata", wdata_o, ed);
      chk("model busy", busy_o, m_g >= 0);
      chk("single ready", $countones(req_ready_o) <= 1, 1'b1);
      chk("no overflow", write_en_o && wfull_i, 1'b0);
   endtask

   task automatic model_update();
      if (!rst_n) begin
         model_reset();
         return;
      end
      if (m_g < 0) begin
         if (arb_en_i && req_valid_i != '0) begin
            for (int k = 1; k <= NR; k++) begin
               int c;
               c = (m_last + k) % NR;
               if (req_valid_i[c]) begin
                  m_g = c;
                  m_beats = 0;
                  break;
               end
            end
         end
      end else begin
         if (req_valid_i[m_g] && !wfull_i) m_beats++;
         if (!req_valid_i[m_g] || m_beats == MB) begin
            m_last = m_g;
            m_g = -1;
         end
      end
   endtask

   task automatic sample();
      @(negedge wclk);
      model_check();
   endtask

   task automatic advance();
      @(posedge wclk);
      model_update();
      #1;
   endtask

   task automatic cycle();
      sample();
      advance();
   endtask

   task automatic set_data(input logic [DW-1:0] d);
      for (int i = 0; i < NR; i++) req_data_i[i*DW +: DW] = d + 32'(i) * 32'h1000_0000;
   endtask

   task automatic rand_data();
      for (int i = 0; i < NR; i++) req_data_i[i*DW +: DW] = $urandom();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) cycle();
      rst_n = 1'b1;
   endtask

   task automatic add(input logic en, input logic full, input logic [NR-1:0] v, input logic [DW-1:0] d,
                      input logic [NR-1:0] eg, input logic [NR-1:0] er, input logic ew, input logic [DW-1:0] ed);
      vec_t r;
      r.en = en; r.full = full; r.valid = v; r.d = d;
      r.e_grant = eg; r.e_ready = er; r.e_we = ew; r.e_wdata = ed;
      tbl.push_back(r);
   endtask

   initial begin
      int seg_src[$];
      int seg_len[$];
      int nb;
      int gi;
      logic prev_we;

      // Single req1 burst of three words, then valid drops.
      add(1, 0, 4'b0010, 32'hA0, 4'b0000, 4'b0000, 0, 32'h0);
      add(1, 0, 4'b0010, 32'hA0, 4'b0010, 4'b0010, 1, 32'h1000_00A0);
      add(1, 0, 4'b0010, 32'hA1, 4'b0010, 4'b0010, 1, 32'h1000_00A1);
      add(1, 0, 4'b0010, 32'hA2, 4'b0010, 4'b0010, 1, 32'h1000_00A2);
      add(1, 0, 4'b0000, 32'hA2, 4'b0010, 4'b0010, 0, 32'h1000_00A2);
      add(1, 0, 4'b0000, 32'hA2, 4'b0000, 4'b0000, 0, 32'h0);
      // req2 burst stalled by full for five cycles after beat 3.
      add(1, 0, 4'b0100, 32'hC0, 4'b0000, 4'b0000, 0, 32'h0);
      for (int k = 0; k < 3; k++)
         add(1, 0, 4'b0100, 32'(32'hC0 + k), 4'b0100, 4'b0100, 1, 32'(32'h2000_00C0 + k));
      for (int k = 0; k < 5; k++)
         add(1, 1, 4'b0100, 32'hC3, 4'b0100, 4'b0000, 0, 32'h2000_00C3);
      for (int k = 3; k < 8; k++)
         add(1, 0, 4'b0100, 32'(32'hC0 + k), 4'b0100, 4'b0100, 1, 32'(32'h2000_00C0 + k));
      add(1, 0, 4'b0100, 32'hC8, 4'b0000, 4'b0000, 0, 32'h0);
      add(1, 0, 4'b0000, 32'hC8, 4'b0100, 4'b0100, 0, 32'h2000_00C8);
      add(1, 0, 4'b0000, 32'hC8, 4'b0000, 4'b0000, 0, 32'h0);

      // Reset held with every requester valid.
      rst_n = 1'b0; arb_en_i = 1'b1; wfull_i = 1'b0; req_valid_i = '1; set_data(32'h11);
      model_reset();
      repeat (3) begin
         sample();
         chk("rst grant", grant_o, 4'b0000);
         chk("rst write_en", write_en_o, 1'b0);
         chk("rst ready", req_ready_o, 4'b0000);
         advance();
      end
      rst_n = 1'b1;
      sample(); chk("idle after rst", grant_o, 4'b0000); advance();
      sample(); chk("first grant req0", grant_o, 4'b0001); advance();

      do_reset();
      foreach (tbl[i]) begin
         arb_en_i = tbl[i].en; wfull_i = tbl[i].full; req_valid_i = tbl[i].valid; set_data(tbl[i].d);
         sample();
         chk($sformatf("vec%0d grant", i), grant_o, tbl[i].e_grant);
         chk($sformatf("vec%0d ready", i), req_ready_o, tbl[i].e_ready);
         chk($sformatf("vec%0d write_en", i), write_en_o, tbl[i].e_we);
         chk($sformatf("vec%0d wdata", i), wdata_o, tbl[i].e_wdata);
         advance();
      end

      // All four continuously valid: five full bursts in round-robin order.
      do_reset();
      req_valid_i = '1; arb_en_i = 1'b1; wfull_i = 1'b0;
      prev_we = 1'b0;
      repeat (46) begin
         rand_data();
         sample();
         if (write_en_o) begin
            gi = -1;
            for (int k = 0; k < NR; k++) if (grant_o[k]) gi = k;
            if (!prev_we) begin
               seg_src.push_back(gi);
               seg_len.push_back(1);
            end else begin
               seg_len[seg_len.size()-1]++;
            end
         end
         prev_we = write_en_o;
         advance();
      end
      chk("rr burst count", seg_src.size(), 5);
      for (int k = 0; k < 5 && k < seg_src.size(); k++) begin
         chk($sformatf("rr src%0d", k), seg_src[k], k % NR);
         chk($sformatf("rr len%0d", k), seg_len[k], MB);
      end

      // arb_en_i dropped mid-burst of req0.
      do_reset();
      req_valid_i = 4'b0011; arb_en_i = 1'b1; wfull_i = 1'b0; set_data(32'h55);
      nb = 0;
      cycle();
      repeat (3) begin sample(); nb += int'(write_en_o); advance(); end
      arb_en_i = 1'b0;
      repeat (5) begin sample(); nb += int'(write_en_o); advance(); end
      chk("disable burst beats", nb, MB);
      repeat (4) begin sample(); chk("hold while disabled", grant_o, 4'b0000); advance(); end
      arb_en_i = 1'b1;
      cycle();
      sample(); chk("grant after enable", grant_o, 4'b0010); advance();

      // Reset pulsed during beat 5 of req3.
      do_reset();
      req_valid_i = 4'b1000; arb_en_i = 1'b1; wfull_i = 1'b0; set_data(32'h66);
      nb = 0;
      cycle();
      repeat (4) begin sample(); nb += int'(write_en_o); advance(); end
      chk("beats before rst", nb, 4);
      #2;
      chk("beat5 grant", grant_o, 4'b1000);
      chk("beat5 write_en", write_en_o, 1'b1);
      rst_n = 1'b0; model_reset();
      #1;
      chk("mid rst write_en", write_en_o, 1'b0);
      chk("mid rst grant", grant_o, 4'b0000);
      chk("mid rst ready", req_ready_o, 4'b0000);
      chk("mid rst wdata", wdata_o, 32'h0);
      chk("mid rst busy", busy_o, 1'b0);
      cycle();
      rst_n = 1'b1; req_valid_i = 4'b1001;
      cycle();
      sample(); chk("restart grant req0", grant_o, 4'b0001); advance();

      // Randomized traffic against the reference model.
      do_reset();
      repeat (800) begin
         for (int k = 0; k < NR; k++) req_valid_i[k] = ($urandom_range(0, 9) < 9);
         wfull_i  = ($urandom_range(0, 4) == 0);
         arb_en_i = ($urandom_range(0, 9) != 0);
         rand_data();
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
